// File: rtl/btb_branch_predictor.sv
// btb_branch_predictor: direct-mapped BTB with saturating counters, ID-resolved update/redirect and perf counters
module btb_branch_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 4,
  parameter int CTR_WIDTH  = 2,
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_IF,
  output logic                  pred_taken_IF,
  output logic [ADDR_WIDTH-1:0] pred_target_IF,
  output logic [ADDR_WIDTH-1:0] npc_IF,
  input  logic                  upd_valid_ID,
  input  logic [ADDR_WIDTH-1:0] upd_pc_ID,
  input  logic                  upd_is_jump_ID,
  input  logic                  upd_taken_ID,
  input  logic [ADDR_WIDTH-1:0] upd_target_ID,
  input  logic                  upd_pred_taken_ID,
  input  logic [ADDR_WIDTH-1:0] upd_pred_target_ID,
  output logic                  mispredict_ID,
  output logic [ADDR_WIDTH-1:0] redirect_pc_ID,
  output logic [PERF_WIDTH-1:0] branch_cnt,
  output logic [PERF_WIDTH-1:0] mispredict_cnt
);
  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam int TW = ADDR_WIDTH - INDEX_BITS - 2;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
  logic [ENTRIES-1:0] valid, is_jump;
  logic [ENTRIES-1:0][TW-1:0] tag;
  logic [ENTRIES-1:0][ADDR_WIDTH-1:0] target;
  logic [ENTRIES-1:0][CTR_WIDTH-1:0] ctr;
  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TW-1:0] lk_tag, up_tag;
  logic lk_hit, up_hit, alloc, wr_en;
  logic [CTR_WIDTH-1:0] cur_ctr, ctr_nxt;
  assign lk_idx = pc_IF[INDEX_BITS+1:2];
  assign lk_tag = pc_IF[ADDR_WIDTH-1:INDEX_BITS+2];
  assign up_idx = upd_pc_ID[INDEX_BITS+1:2];
  assign up_tag = upd_pc_ID[ADDR_WIDTH-1:INDEX_BITS+2];
  assign lk_hit = valid[lk_idx] && tag[lk_idx] == lk_tag;
  assign up_hit = valid[up_idx] && tag[up_idx] == up_tag;
  assign pred_taken_IF = lk_hit && (is_jump[lk_idx] || ctr[lk_idx][CTR_WIDTH-1]);
  assign pred_target_IF = pred_taken_IF ? target[lk_idx] : '0;
  assign mispredict_ID = upd_valid_ID && ((upd_pred_taken_ID != upd_taken_ID) ||
                         (upd_taken_ID && upd_pred_target_ID != upd_target_ID));
  assign redirect_pc_ID = upd_taken_ID ? upd_target_ID : upd_pc_ID + ADDR_WIDTH'(4);
  assign npc_IF = mispredict_ID ? redirect_pc_ID :
                  pred_taken_IF ? pred_target_IF : pc_IF + ADDR_WIDTH'(4);
  assign alloc = upd_valid_ID && !up_hit && upd_taken_ID;
  assign wr_en = upd_valid_ID && (up_hit || upd_taken_ID);
  assign cur_ctr = ctr[up_idx];
  always_comb begin
    ctr_nxt = cur_ctr;
    if (!up_hit || upd_is_jump_ID)
      ctr_nxt = upd_is_jump_ID ? CTR_MAX : CTR_WEAK;
    else if (upd_taken_ID)
      ctr_nxt = cur_ctr == CTR_MAX ? cur_ctr : cur_ctr + CTR_WIDTH'(1);
    else
      ctr_nxt = cur_ctr == '0 ? cur_ctr : cur_ctr - CTR_WIDTH'(1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      ctr <= '0;
      branch_cnt <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (wr_en) begin
        ctr[up_idx] <= ctr_nxt;
        if (alloc) valid[up_idx] <= 1'b1;
      end
      if (upd_valid_ID && ~&branch_cnt) branch_cnt <= branch_cnt + PERF_WIDTH'(1);
      if (mispredict_ID && ~&mispredict_cnt) mispredict_cnt <= mispredict_cnt + PERF_WIDTH'(1);
    end
  end
  // Tag/target/kind need no reset: a cleared valid bit hides them.
  always_ff @(posedge clock) begin
    if (!reset && wr_en && upd_taken_ID) target[up_idx] <= upd_target_ID;
    if (!reset && alloc) begin
      tag[up_idx] <= up_tag;
      is_jump[up_idx] <= upd_is_jump_ID;
    end
  end
endmodule

// File: tb/tb_btb_branch_predictor.sv
// tb_btb_branch_predictor: random + directed check of the BTB predictor against a behavioural model
module tb_btb_branch_predictor;
  localparam int PW = 4;
  localparam int PMAX = 15;
  logic clock = 0, reset;
  logic [31:0] pc_IF, pred_target_IF, npc_IF, upd_pc_ID, upd_target_ID, upd_pred_target_ID, redirect_pc_ID;
  logic pred_taken_IF, upd_valid_ID, upd_is_jump_ID, upd_taken_ID, upd_pred_taken_ID, mispredict_ID;
  logic [PW-1:0] branch_cnt, mispredict_cnt;
  int passed = 0, total = 0;
  bit chk_en = 0;
  bit m_v[16], m_j[16];
  int m_c[16];
  logic [31:0] m_t[16], m_g[16];
  int bc = 0, mc = 0;
  btb_branch_predictor #(.ADDR_WIDTH(32), .INDEX_BITS(4), .CTR_WIDTH(2), .PERF_WIDTH(PW)) dut (
    .clock(clock), .reset(reset), .pc_IF(pc_IF), .pred_taken_IF(pred_taken_IF),
    .pred_target_IF(pred_target_IF), .npc_IF(npc_IF), .upd_valid_ID(upd_valid_ID),
    .upd_pc_ID(upd_pc_ID), .upd_is_jump_ID(upd_is_jump_ID), .upd_taken_ID(upd_taken_ID),
    .upd_target_ID(upd_target_ID), .upd_pred_taken_ID(upd_pred_taken_ID),
    .upd_pred_target_ID(upd_pred_target_ID), .mispredict_ID(mispredict_ID),
    .redirect_pc_ID(redirect_pc_ID), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt));
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  function automatic void model_lookup(input logic [31:0] pc, output bit pt, output logic [31:0] tg);
    int i;
    i = (pc / 4) % 16;
    pt = m_v[i] && m_t[i] == pc / 64 && (m_j[i] || m_c[i] >= 2);
    tg = pt ? m_g[i] : 32'd0;
  endfunction
  function automatic bit model_mp();
    return upd_valid_ID && ((upd_pred_taken_ID != upd_taken_ID) ||
           (upd_taken_ID && upd_pred_target_ID != upd_target_ID));
  endfunction
  always @(posedge clock) begin
    int i;
    i = (upd_pc_ID / 4) % 16;
    if (reset) begin
      for (int k = 0; k < 16; k++) begin m_v[k] = 0; m_c[k] = 0; end
      bc = 0; mc = 0;
    end else if (upd_valid_ID) begin
      if (model_mp() && mc < PMAX) mc++;
      if (bc < PMAX) bc++;
      if (m_v[i] && m_t[i] == upd_pc_ID / 64) begin
        if (upd_is_jump_ID) begin m_c[i] = 3; m_g[i] = upd_target_ID; end
        else if (upd_taken_ID) begin m_c[i] = m_c[i] < 3 ? m_c[i] + 1 : 3; m_g[i] = upd_target_ID; end
        else m_c[i] = m_c[i] > 0 ? m_c[i] - 1 : 0;
      end else if (upd_taken_ID) begin
        m_v[i] = 1; m_t[i] = upd_pc_ID / 64; m_g[i] = upd_target_ID;
        m_j[i] = upd_is_jump_ID; m_c[i] = upd_is_jump_ID ? 3 : 2;
      end
    end
  end
  always @(negedge clock) if (chk_en) begin
    bit pt, mp;
    logic [31:0] tg, rd;
    model_lookup(pc_IF, pt, tg);
    mp = model_mp();
    rd = upd_taken_ID ? upd_target_ID : upd_pc_ID + 4;
    chk("pred_taken", 32'(pred_taken_IF), 32'(pt));
    chk("pred_target", pred_target_IF, tg);
    chk("mispredict", 32'(mispredict_ID), 32'(mp));
    chk("redirect", redirect_pc_ID, rd);
    chk("npc", npc_IF, mp ? rd : pt ? tg : pc_IF + 4);
    chk("branch_cnt", 32'(branch_cnt), 32'(bc));
    chk("mispredict_cnt", 32'(mispredict_cnt), 32'(mc));
  end
  task automatic upd(input bit v, input logic [31:0] pc, input bit j, input bit tk,
                     input logic [31:0] tg, input bit pt, input logic [31:0] ptg);
    upd_valid_ID = v; upd_pc_ID = pc; upd_is_jump_ID = j; upd_taken_ID = tk;
    upd_target_ID = tg; upd_pred_taken_ID = pt; upd_pred_target_ID = ptg;
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic idle(input logic [31:0] pc);
    upd(0, 32'h3000, 0, 0, 0, 0, 0);
    pc_IF = pc;
    @(negedge clock);
  endtask
  initial begin
    reset = 1; pc_IF = 32'h3000;
    upd(0, 32'h3000, 0, 0, 0, 0, 0);
    step();
    chk_en = 1;
    step();
    reset = 0;
    idle(32'h3000);
    chk("rst_pred", 32'(pred_taken_IF), 0);
    chk("rst_npc", npc_IF, 32'h3004);
    chk("rst_bcnt", 32'(branch_cnt), 0);
    chk("rst_mcnt", 32'(mispredict_cnt), 0);
    step();
    upd(1, 32'h3010, 0, 1, 32'h3040, 0, 0);
    @(negedge clock);
    chk("beq_mp", 32'(mispredict_ID), 1);
    chk("beq_redirect", redirect_pc_ID, 32'h3040);
    chk("beq_npc", npc_IF, 32'h3040);
    step();
    idle(32'h3010);
    chk("alloc_pred", 32'(pred_taken_IF), 1);
    chk("alloc_tgt", pred_target_IF, 32'h3040);
    chk("alloc_mcnt", 32'(mispredict_cnt), 1);
    step();
    upd(1, 32'h3010, 0, 0, 32'h3040, 1, 32'h3040);
    @(negedge clock);
    chk("nt_mp", 32'(mispredict_ID), 1);
    chk("nt_redirect", redirect_pc_ID, 32'h3014);
    step();
    idle(32'h3010);
    chk("ctr1_pred", 32'(pred_taken_IF), 0);
    step();
    repeat (3) begin
      upd(1, 32'h3010, 0, 1, 32'h3040, 0, 0);
      step();
      idle(32'h3010);
      chk("walk_pred", 32'(pred_taken_IF), 1);
      step();
    end
    upd(1, 32'h3010, 0, 0, 32'h3040, 1, 32'h3040);
    step();
    idle(32'h3010);
    chk("sat_pred", 32'(pred_taken_IF), 1);
    step();
    upd(1, 32'h3020, 1, 1, 32'h3100, 0, 0);
    step();
    idle(32'h3020);
    chk("j_pred", 32'(pred_taken_IF), 1);
    chk("j_tgt", pred_target_IF, 32'h3100);
    step();
    upd(1, 32'h3020, 1, 1, 32'h3100, 1, 32'h3100);
    @(negedge clock);
    chk("j_no_mp", 32'(mispredict_ID), 0);
    step();
    upd(1, 32'h3050, 0, 1, 32'h3200, 0, 0);
    pc_IF = 32'h3050;
    @(negedge clock);
    chk("same_cyc_old", 32'(pred_taken_IF), 0);
    step();
    idle(32'h3010);
    chk("evicted", 32'(pred_taken_IF), 0);
    step();
    idle(32'h3050);
    chk("conflict_hit", 32'(pred_taken_IF), 1);
    chk("conflict_tgt", pred_target_IF, 32'h3200);
    step();
    reset = 1;
    upd(1, 32'h3060, 0, 1, 32'h3300, 0, 0);
    step();
    reset = 0;
    idle(32'h3060);
    chk("rst_noalloc", 32'(pred_taken_IF), 0);
    chk("rst_bcnt2", 32'(branch_cnt), 0);
    step();
    idle(32'h3020);
    chk("rst_inval", 32'(pred_taken_IF), 0);
    step();
    repeat (PMAX + 2) begin
      upd(1, 32'h3070, 0, 1, 32'h3400, 0, 0);
      step();
    end
    idle(32'h3000);
    chk("sat_mcnt", 32'(mispredict_cnt), PMAX);
    chk("sat_bcnt", 32'(branch_cnt), PMAX);
    step();
    for (int n = 0; n < 800; n++) begin
      bit pt, j, tk;
      logic [31:0] tg, pc;
      reset = $urandom_range(0, 63) == 0;
      pc_IF = 32'h3000 + 4 * $urandom_range(0, 47);
      pc = 32'h3000 + 4 * $urandom_range(0, 47);
      j = $urandom_range(0, 3) == 0;
      tk = j || $urandom_range(0, 1);
      model_lookup(pc, pt, tg);
      if ($urandom_range(0, 3) == 0) begin
        pt = $urandom_range(0, 1);
        tg = 32'h4000 + 4 * $urandom_range(0, 3);
      end
      upd($urandom_range(0, 2) != 0, pc, j, tk, 32'h4000 + 4 * $urandom_range(0, 3), pt, tg);
      step();
    end
    reset = 0;
    upd(0, 32'h3000, 0, 0, 0, 0, 0);
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
